ahb_lite_master_if: RTL and testbench

//  Single-master AHB-Lite bus interface. Sits directly upstream of the AHB SRAM slave.

---
 rtl/ahb_lite_master_if_pkg.sv | 20 ++
 rtl/ahb_lite_master_if_if.sv | 41 ++++
 rtl/ahb_lite_master_if.sv | 153 +++++++++++++++
 tb/tb_ahb_lite_master_if.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_master_if_pkg.sv
// ahb_lite_master_if_pkg: shared AHB-Lite encodings and master FSM states
package ahb_lite_master_if_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

endpackage

// File: rtl/ahb_lite_master_if_if.sv
// ahb_lite_master_if_if: CPU request/response channel plus AHB-Lite bus signals
interface ahb_lite_master_if_if;

    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_write;
    logic [2:0]  cpu_req_size;
    logic [31:0] cpu_req_wdata;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;
    logic        cpu_rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    // The bus master: drives AHB requests and CPU responses
    modport master (
        input  cpu_req_valid, cpu_req_addr, cpu_req_write, cpu_req_size, cpu_req_wdata,
        input  HRDATA, HREADY, HRESP,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    // The surroundings: CPU side plus the AHB slave
    modport slave (
        output cpu_req_valid, cpu_req_addr, cpu_req_write, cpu_req_size, cpu_req_wdata,
        output HRDATA, HREADY, HRESP,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

endinterface

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if: turns CPU valid/ready requests into AHB-Lite SINGLE transfers
module ahb_lite_master_if
    import ahb_lite_master_if_pkg::*;
#(
    parameter int         TIMEOUT   = 255,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_master_if_if.master  bus
);

    localparam int             CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TO = CW'(TIMEOUT);

    function automatic logic f_misaligned(input logic [2:0] size, input logic [1:0] a);
        return (size > HSIZE_WORD) || (size == HSIZE_HALF && a[0]) ||
               (size == HSIZE_WORD && a != 2'b00);
    endfunction

    state_t        r_state, w_state;
    logic [31:0]   r_haddr, w_haddr;
    logic [1:0]    r_htrans, w_htrans;
    logic          r_hwrite, w_hwrite;
    logic [2:0]    r_hsize, w_hsize;
    logic [31:0]   r_hwdata, w_hwdata;
    logic [31:0]   r_wdata, w_wdata;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_rsp_valid, w_rsp_valid;
    logic [31:0]   r_rsp_rdata, w_rsp_rdata;
    logic          r_rsp_err, w_rsp_err;
    logic          r_pend, w_pend;
    logic          w_complete;
    logic          w_ready;
    logic          w_accept;
    logic          w_mis;

    // A misaligned request taken on a completing cycle must wait one cycle for its
    // error strobe, so ready is withheld in IDLE while that strobe is pending.
    assign w_complete = (r_state == ST_DATA) && bus.HREADY && (bus.HRESP == HRESP_OKAY);
    assign w_ready    = ((r_state == ST_IDLE) && !r_pend) || w_complete;
    assign w_accept   = bus.cpu_req_valid && w_ready;
    assign w_mis      = f_misaligned(bus.cpu_req_size, bus.cpu_req_addr[1:0]);

    assign bus.cpu_req_ready = w_ready;
    assign bus.cpu_rsp_valid = r_rsp_valid;
    assign bus.cpu_rsp_rdata = r_rsp_rdata;
    assign bus.cpu_rsp_err   = r_rsp_err;
    assign bus.HADDR         = r_haddr;
    assign bus.HTRANS        = r_htrans;
    assign bus.HWRITE        = r_hwrite;
    assign bus.HSIZE         = r_hsize;
    assign bus.HWDATA        = r_hwdata;
    assign bus.HBURST        = HBURST_SINGLE;
    assign bus.HPROT         = HPROT_VAL;
    assign bus.HMASTLOCK     = 1'b0;

    // Next-state and next-output logic: phase sequencing, responses and request capture
    always_comb begin
        w_state     = r_state;
        w_haddr     = r_haddr;
        w_htrans    = r_htrans;
        w_hwrite    = r_hwrite;
        w_hsize     = r_hsize;
        w_hwdata    = r_hwdata;
        w_wdata     = r_wdata;
        w_cnt       = r_cnt;
        w_rsp_valid = r_pend;
        w_rsp_rdata = '0;
        w_rsp_err   = r_pend;
        w_pend      = 1'b0;
        case (r_state)
            ST_ADDR: begin
                if (bus.HREADY) begin
                    w_htrans = HTRANS_IDLE;
                    w_hwdata = r_wdata;
                    w_cnt    = '0;
                    w_state  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_complete) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = r_hwrite ? 32'h0 : bus.HRDATA;
                    w_state     = ST_IDLE;
                end else if (bus.HRESP == HRESP_ERROR) begin
                    w_rsp_valid = bus.HREADY;
                    w_rsp_err   = bus.HREADY;
                    w_state     = bus.HREADY ? ST_IDLE : ST_ERR;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                    if (TIMEOUT != 0 && w_cnt == TO) begin
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_state     = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                if (bus.HREADY) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_state     = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (w_accept && w_mis) begin
            w_pend      = w_complete;
            w_rsp_valid = w_rsp_valid | !w_complete;
            w_rsp_err   = w_rsp_err | !w_complete;
        end else if (w_accept) begin
            w_haddr  = bus.cpu_req_addr;
            w_hwrite = bus.cpu_req_write;
            w_hsize  = bus.cpu_req_size;
            w_wdata  = bus.cpu_req_wdata;
            w_htrans = HTRANS_NONSEQ;
            w_state  = ST_ADDR;
        end
    end

    // State and registered outputs, cleared asynchronously by HRESETn
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_haddr     <= '0;
            r_htrans    <= HTRANS_IDLE;
            r_hwrite    <= 1'b0;
            r_hsize     <= HSIZE_WORD;
            r_hwdata    <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_pend      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_haddr     <= w_haddr;
            r_htrans    <= w_htrans;
            r_hwrite    <= w_hwrite;
            r_hsize     <= w_hsize;
            r_hwdata    <= w_hwdata;
            r_wdata     <= w_wdata;
            r_cnt       <= w_cnt;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_pend      <= w_pend;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// tb_ahb_lite_master_if: directed self-checking bench for the AHB-Lite master
module tb_ahb_lite_master_if;
    import ahb_lite_master_if_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    ahb_lite_master_if_if bus ();

    ahb_lite_master_if #(.TIMEOUT(4), .HPROT_VAL(4'b0011)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = a;
        bus.cpu_req_write = w;
        bus.cpu_req_size  = s;
        bus.cpu_req_wdata = d;
    endtask

    initial begin
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_addr  = '0;
        bus.cpu_req_write = 1'b0;
        bus.cpu_req_size  = HSIZE_WORD;
        bus.cpu_req_wdata = '0;
        bus.HRDATA        = '0;
        bus.HREADY        = 1'b1;
        bus.HRESP         = 1'b0;
        tick();
        tick();
        chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_hsize", 32'(bus.HSIZE), 32'h2);
        chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        chk("rst_rsp_valid", 32'(bus.cpu_rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(bus.cpu_rsp_err), 32'h0);
        chk("rst_rsp_rdata", bus.cpu_rsp_rdata, 32'h0);
        chk("const_hburst", 32'(bus.HBURST), 32'h0);
        chk("const_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
        chk("const_hprot", 32'(bus.HPROT), 32'h3);
        HRESETn = 1'b1;
        tick();

        // 1: single word read, zero wait states
        req(32'h0010_0008, 1'b0, 3'd2, 32'h0);
        #1 chk("t1_ready_idle", 32'(bus.cpu_req_ready), 32'h1);
        tick();
        bus.cpu_req_valid = 1'b0;
        chk("t1_nonseq", 32'(bus.HTRANS), 32'h2);
        chk("t1_haddr", bus.HADDR, 32'h0010_0008);
        chk("t1_hwrite", 32'(bus.HWRITE), 32'h0);
        #1 chk("t1_ready_addr", 32'(bus.cpu_req_ready), 32'h0);
        tick();
        chk("t1_htrans_data", 32'(bus.HTRANS), 32'h0);
        chk("t1_rsp_early", 32'(bus.cpu_rsp_valid), 32'h0);
        bus.HRDATA = 32'hDEAD_BEEF;
        tick();
        bus.HRDATA = '0;
        chk("t1_rsp_valid", 32'(bus.cpu_rsp_valid), 32'h1);
        chk("t1_rdata", bus.cpu_rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_err", 32'(bus.cpu_rsp_err), 32'h0);
        tick();
        chk("t1_rsp_strobe", 32'(bus.cpu_rsp_valid), 32'h0);

        // 2: write then back-to-back read of the same word
        req(32'h0010_0004, 1'b1, 3'd2, 32'h1234_5678);
        tick();
        chk("t2_nonseq_w", 32'(bus.HTRANS), 32'h2);
        chk("t2_hwrite", 32'(bus.HWRITE), 32'h1);
        chk("t2_haddr", bus.HADDR, 32'h0010_0004);
        req(32'h0010_0004, 1'b0, 3'd2, 32'h1234_5678);
        tick();
        chk("t2_hwdata", bus.HWDATA, 32'h1234_5678);
        chk("t2_htrans_data", 32'(bus.HTRANS), 32'h0);
        #1 chk("t2_ready_complete", 32'(bus.cpu_req_ready), 32'h1);
        tick();
        bus.cpu_req_valid = 1'b0;
        chk("t2_wr_rsp", 32'(bus.cpu_rsp_valid), 32'h1);
        chk("t2_wr_rdata", bus.cpu_rsp_rdata, 32'h0);
        chk("t2_wr_err", 32'(bus.cpu_rsp_err), 32'h0);
        chk("t2_nonseq_r", 32'(bus.HTRANS), 32'h2);
        chk("t2_hwrite_r", 32'(bus.HWRITE), 32'h0);
        tick();
        chk("t2_rsp_gap", 32'(bus.cpu_rsp_valid), 32'h0);
        bus.HRDATA = 32'h1234_5678;
        tick();
        bus.HRDATA = '0;
        chk("t2_rd_rsp", 32'(bus.cpu_rsp_valid), 32'h1);
        chk("t2_rd_rdata", bus.cpu_rsp_rdata, 32'h1234_5678);
        chk("t2_rd_err", 32'(bus.cpu_rsp_err), 32'h0);

        // 3: write with three slave wait states
        req(32'h0010_0000, 1'b1, 3'd2, 32'hA5A5_0001);
        tick();
        bus.cpu_req_valid = 1'b0;
        tick();
        bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hwdata_held", bus.HWDATA, 32'hA5A5_0001);
            chk("t3_rsp_wait", 32'(bus.cpu_rsp_valid), 32'h0);
        end
        bus.HREADY = 1'b1;
        tick();
        chk("t3_rsp_valid", 32'(bus.cpu_rsp_valid), 32'h1);
        chk("t3_err", 32'(bus.cpu_rsp_err), 32'h0);

        // 4: two-cycle ERROR response
        req(32'h0010_0010, 1'b0, 3'd2, 32'h0);
        tick();
        bus.cpu_req_valid = 1'b0;
        tick();
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        tick();
        bus.HREADY = 1'b1;
        #1 chk("t4_ready_err", 32'(bus.cpu_req_ready), 32'h0);
        chk("t4_rsp_early", 32'(bus.cpu_rsp_valid), 32'h0);
        tick();
        bus.HRESP = 1'b0;
        chk("t4_rsp_valid", 32'(bus.cpu_rsp_valid), 32'h1);
        chk("t4_err", 32'(bus.cpu_rsp_err), 32'h1);
        #1 chk("t4_ready_idle", 32'(bus.cpu_req_ready), 32'h1);

        // 5: misaligned requests never reach the bus
        req(32'h0010_0002, 1'b0, 3'd2, 32'h0);
        tick();
        bus.cpu_req_valid = 1'b0;
        chk("t5_htrans", 32'(bus.HTRANS), 32'h0);
        chk("t5_rsp_valid", 32'(bus.cpu_rsp_valid), 32'h1);
        chk("t5_err", 32'(bus.cpu_rsp_err), 32'h1);
        tick();
        chk("t5_rsp_strobe", 32'(bus.cpu_rsp_valid), 32'h0);
        req(32'h0010_0001, 1'b1, 3'd1, 32'h0);
        tick();
        bus.cpu_req_valid = 1'b0;
        chk("t5_half_htrans", 32'(bus.HTRANS), 32'h0);
        chk("t5_half_err", 32'(bus.cpu_rsp_err), 32'h1);
        req(32'h0010_0000, 1'b0, 3'd3, 32'h0);
        tick();
        bus.cpu_req_valid = 1'b0;
        chk("t5_size3_htrans", 32'(bus.HTRANS), 32'h0);
        chk("t5_size3_err", 32'(bus.cpu_rsp_err), 32'h1);
        tick();

        // 6: hung bus times out after four wait cycles
        req(32'h0010_0020, 1'b0, 3'd2, 32'h0);
        tick();
        bus.cpu_req_valid = 1'b0;
        tick();
        bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_timeout_yet", 32'(bus.cpu_rsp_valid), 32'h0);
        end
        tick();
        chk("t6_timeout_valid", 32'(bus.cpu_rsp_valid), 32'h1);
        chk("t6_timeout_err", 32'(bus.cpu_rsp_err), 32'h1);
        bus.HREADY = 1'b1;
        #1 chk("t6_ready_idle", 32'(bus.cpu_req_ready), 32'h1);
        tick();

        // 6b: reset in the middle of a data phase
        req(32'h0010_0030, 1'b1, 3'd2, 32'hCAFE_F00D);
        tick();
        bus.cpu_req_valid = 1'b0;
        tick();
        bus.HREADY = 1'b0;
        tick();
        chk("t6b_hwdata_pre", bus.HWDATA, 32'hCAFE_F00D);
        HRESETn = 1'b0;
        #1;
        chk("t6b_htrans", 32'(bus.HTRANS), 32'h0);
        chk("t6b_rsp_valid", 32'(bus.cpu_rsp_valid), 32'h0);
        chk("t6b_hwdata", bus.HWDATA, 32'h0);
        chk("t6b_haddr", bus.HADDR, 32'h0);
        bus.HREADY = 1'b1;
        tick();
        HRESETn = 1'b1;
        tick();
        chk("t6b_no_rsp", 32'(bus.cpu_rsp_valid), 32'h0);
        tick();
        chk("t6b_no_rsp2", 32'(bus.cpu_rsp_valid), 32'h0);
        chk("t6b_ready", 32'(bus.cpu_req_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
